// File: rtl/osc_meter_pkg.sv
// Shared types and sizing helpers for the oscillator edge-count measurement stages.
package osc_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SETTLE_CYCLES = 2;

    // Never narrower than 1 bit, so that the SETTLE phase can still count two cycles.
    function automatic int timer_width(input int window);
        int w;
        w = $clog2(window);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/osc_edge_counter_sync_edge_det.sv
// Two-flop synchroniser plus history flop; flags a rising edge of an input that is asynchronous to clk.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic inp,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= inp;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/osc_edge_counter.sv
// Counts rising edges of an oscillator output over a gate window of WINDOW clk cycles.
//   state  | meaning
//   IDLE   | waiting for start; result and ovf hold the last measurement
//   SETTLE | two cycles that flush the synchroniser; no counting
//   COUNT  | WINDOW cycles; each detected rise increments the saturating counter
//   DONE   | one cycle; valid pulses, result and ovf show the new measurement
module osc_edge_counter
    import osc_meter_pkg::*;
#(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             valid,
    output logic             ovf
);

    localparam int TW = timer_width(WINDOW);

    state_t            state, state_nxt;
    logic [TW-1:0]     timer;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              sat, sat_nxt;
    logic              rise;
    logic              settle_last, count_last;

    sync_edge_det u_sync (
        .clk  (clk),
        .rst  (rst),
        .inp  (inp),
        .rise (rise)
    );

    assign settle_last = (timer == TW'(SETTLE_CYCLES - 1));
    assign count_last  = (timer == TW'(WINDOW - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settle_last) state_nxt = COUNT;
            COUNT:   if (count_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == SETTLE) || (state == COUNT);
        valid = (state == DONE);
    end

    // A rise at the saturated value keeps the count and only raises the flag.
    always_comb begin
        cnt_nxt = cnt;
        sat_nxt = sat;
        if (rise) begin
            if (cnt == '1) begin
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // The final count is captured on the last COUNT edge so result is already valid during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer  <= '0;
            cnt    <= '0;
            sat    <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                end
                SETTLE: begin
                    if (settle_last) begin
                        timer <= '0;
                        cnt   <= '0;
                        sat   <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                COUNT: begin
                    timer <= timer + 1'b1;
                    cnt   <= cnt_nxt;
                    sat   <= sat_nxt;
                    if (count_last) begin
                        result <= cnt_nxt;
                        ovf    <= sat_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osc_edge_counter.sv
// Directed bench for osc_edge_counter: three instances cover WINDOW=100, WINDOW=1000 and a 4-bit counter.
module tb_osc_edge_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inp;
    logic        start_a, start_b, start_c;
    logic        busy_a, valid_a, ovf_a;
    logic        busy_b, valid_b, ovf_b;
    logic        busy_c, valid_c, ovf_c;
    logic [15:0] result_a, result_b;
    logic [3:0]  result_c;

    int n_cmp = 0;
    int n_bad = 0;
    int inp_mode = 0;
    int ph = 0;
    int sel = 0;

    logic        m_busy, m_valid, m_ovf;
    logic [31:0] m_res;

    always #5 clk = ~clk;

    osc_edge_counter #(.WINDOW(100), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .inp(inp), .start(start_a),
        .busy(busy_a), .result(result_a), .valid(valid_a), .ovf(ovf_a)
    );

    osc_edge_counter #(.WINDOW(1000), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .inp(inp), .start(start_b),
        .busy(busy_b), .result(result_b), .valid(valid_b), .ovf(ovf_b)
    );

    osc_edge_counter #(.WINDOW(100), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .inp(inp), .start(start_c),
        .busy(busy_c), .result(result_c), .valid(valid_c), .ovf(ovf_c)
    );

    always_comb begin
        m_busy  = busy_a;
        m_valid = valid_a;
        m_ovf   = ovf_a;
        m_res   = 32'(result_a);
        case (sel)
            1: begin
                m_busy  = busy_b;
                m_valid = valid_b;
                m_ovf   = ovf_b;
                m_res   = 32'(result_b);
            end
            2: begin
                m_busy  = busy_c;
                m_valid = valid_c;
                m_ovf   = ovf_c;
                m_res   = 32'(result_c);
            end
            default: begin
            end
        endcase
    end

    // Oscillator model: 0 = held low, 1 = toggles every clk, 2 = period 10 (5 high / 5 low).
    initial begin
        inp = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (inp_mode)
                0: inp = 1'b0;
                1: inp = ~inp;
                default: begin
                    inp = (ph < 5);
                    ph  = (ph == 9) ? 0 : ph + 1;
                end
            endcase
        end
    end

    task automatic set_start(input int s, input logic v);
        case (s)
            1:       start_b = v;
            2:       start_c = v;
            default: start_a = v;
        endcase
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse, then observe until valid; cycle 1 is the cycle after start is sampled.
    task automatic measure(input int s, output int lat, output int bcyc, output int res, output int ov);
        sel  = s;
        lat  = -1;
        bcyc = 0;
        res  = -1;
        ov   = -1;
        set_start(s, 1'b1);
        step(1);
        set_start(s, 1'b0);
        for (int c = 1; c <= 3000; c++) begin
            if (m_busy) bcyc++;
            if (m_valid) begin
                lat = c;
                res = int'(m_res);
                ov  = int'(m_ovf);
                break;
            end
            step(1);
        end
        step(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        inp_mode = 0;
        step(3);
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", valid_a); end
        n_cmp++; if (result_a !== 16'd0) begin n_bad++; $display("FAIL reset_result got %0d want 0", result_a); end
        n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0b want 0", ovf_a); end
        n_cmp++; if (result_c !== 4'd0 || ovf_c !== 1'b0) begin n_bad++; $display("FAIL reset_c got %0d/%0b want 0/0", result_c, ovf_c); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_idle_input();
        int lat, bcyc, res, ov;
        inp_mode = 0;
        step(4);
        measure(0, lat, bcyc, res, ov);
        n_cmp++; if (lat !== 103) begin n_bad++; $display("FAIL idle_latency got %0d want 103", lat); end
        n_cmp++; if (bcyc !== 102) begin n_bad++; $display("FAIL idle_busy_cycles got %0d want 102", bcyc); end
        n_cmp++; if (res !== 0) begin n_bad++; $display("FAIL idle_result got %0d want 0", res); end
        n_cmp++; if (ov !== 0) begin n_bad++; $display("FAIL idle_ovf got %0d want 0", ov); end
    endtask

    task automatic test_toggle();
        int lat, bcyc, res, ov;
        inp_mode = 1;
        step(4);
        measure(0, lat, bcyc, res, ov);
        n_cmp++; if (lat !== 103) begin n_bad++; $display("FAIL toggle_latency got %0d want 103", lat); end
        n_cmp++; if (res !== 50) begin n_bad++; $display("FAIL toggle_result got %0d want 50", res); end
        n_cmp++; if (ov !== 0) begin n_bad++; $display("FAIL toggle_ovf got %0d want 0", ov); end
        step(5);
        n_cmp++; if (result_a !== 16'd50 || valid_a !== 1'b0) begin
            n_bad++; $display("FAIL toggle_hold got %0d/%0b want 50/0", result_a, valid_a);
        end
    endtask

    task automatic test_rst_mid();
        int lat, bcyc, res, ov, nv;
        inp_mode = 1;
        sel = 0;
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(51);
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got %0b want 1", busy_a); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %0b want 0", busy_a); end
        n_cmp++; if (result_a !== 16'd0) begin n_bad++; $display("FAIL rstmid_result got %0d want 0", result_a); end
        n_cmp++; if (ovf_a !== 1'b0) begin n_bad++; $display("FAIL rstmid_ovf got %0b want 0", ovf_a); end
        nv = 0;
        for (int c = 0; c < 150; c++) begin
            if (valid_a) nv++;
            step(1);
        end
        n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL rstmid_no_valid got %0d pulses want 0", nv); end
        measure(0, lat, bcyc, res, ov);
        n_cmp++; if (res !== 50 || lat !== 103) begin
            n_bad++; $display("FAIL rstmid_fresh got result %0d latency %0d want 50 103", res, lat);
        end
    endtask

    task automatic test_start_ignored();
        int nv;
        inp_mode = 1;
        sel = 0;
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(52);
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL ignore_busy_mid got %0b want 1", busy_a); end
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        nv = 0;
        for (int c = 0; c < 200; c++) begin
            if (valid_a) nv++;
            step(1);
        end
        n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL ignore_valid_count got %0d want 1", nv); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL ignore_busy_after got %0b want 0", busy_a); end
    endtask

    task automatic test_back_to_back();
        int v1, v2, nv;
        inp_mode = 0;
        step(3);
        v1 = -1;
        v2 = -1;
        nv = 0;
        start_a = 1'b1;
        step(1);
        for (int c = 1; c <= 300; c++) begin
            if (valid_a) begin
                nv++;
                if (nv == 1) v1 = c;
                if (nv == 2) begin
                    v2 = c;
                    start_a = 1'b0;
                    break;
                end
            end
            step(1);
        end
        start_a = 1'b0;
        n_cmp++; if (v1 !== 103) begin n_bad++; $display("FAIL b2b_first_valid got %0d want 103", v1); end
        n_cmp++; if (v2 !== 207) begin n_bad++; $display("FAIL b2b_second_valid got %0d want 207", v2); end
        step(3);
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL b2b_stopped got busy %0b want 0", busy_a); end
    endtask

    task automatic test_period10();
        int lat, bcyc, res, ov;
        inp_mode = 2;
        step(12);
        measure(1, lat, bcyc, res, ov);
        n_cmp++; if (lat !== 1003) begin n_bad++; $display("FAIL p10_latency got %0d want 1003", lat); end
        n_cmp++; if (bcyc !== 1002) begin n_bad++; $display("FAIL p10_busy_cycles got %0d want 1002", bcyc); end
        n_cmp++; if (res !== 100) begin n_bad++; $display("FAIL p10_result got %0d want 100", res); end
        n_cmp++; if (ov !== 0) begin n_bad++; $display("FAIL p10_ovf got %0d want 0", ov); end
    endtask

    task automatic test_saturate();
        int lat, bcyc, res, ov;
        inp_mode = 1;
        step(4);
        measure(2, lat, bcyc, res, ov);
        n_cmp++; if (res !== 15) begin n_bad++; $display("FAIL sat_result got %0d want 15", res); end
        n_cmp++; if (ov !== 1) begin n_bad++; $display("FAIL sat_ovf got %0d want 1", ov); end
        inp_mode = 0;
        step(6);
        n_cmp++; if (result_c !== 4'd15 || ovf_c !== 1'b1) begin
            n_bad++; $display("FAIL sat_hold got %0d/%0b want 15/1", result_c, ovf_c);
        end
        measure(2, lat, bcyc, res, ov);
        n_cmp++; if (res !== 0) begin n_bad++; $display("FAIL sat_clear_result got %0d want 0", res); end
        n_cmp++; if (ov !== 0) begin n_bad++; $display("FAIL sat_clear_ovf got %0d want 0", ov); end
    endtask

    initial begin
        test_reset();
        test_idle_input();
        test_toggle();
        test_rst_mid();
        test_start_ignored();
        test_back_to_back();
        test_period10();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
